// File: rtl/mem_responder.sv
// mem_responder
//   Target end of the multicycle MIPS memory bus. It serves as the single unified
//   instruction/data memory. It adds a req/ready handshake with a fixed number of
//   wait states. The latched address decodes to one of four targets: word RAM, an
//   LED latch, a free-running cycle counter, or an error response.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit RAM words (word index = adr[31:2])
//   WAIT_CYCLES  wait states per transaction, 0..255
//   MMIO_BASE    LED register at MMIO_BASE, cycle counter at MMIO_BASE+4
//
// Ports
//   clk        in   1   single clock, posedge
//   reset      in   1   synchronous, active-high
//   req        in   1   transaction request, held high until ready
//   adr        in   32  byte address, sampled with req
//   writedata  in   32  write data, sampled with req
//   memwrite   in   1   1 = write, 0 = read
//   readdata   out  32  read result, held until the next commit
//   ready      out  1   one-cycle completion pulse
//   err        out  1   error flag, meaningful while ready=1
//   leds       out  8   MMIO LED register
module mem_responder #(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err,
  output logic [7:0]  leds
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_next;
  logic [7:0]    wcnt;
  logic [31:0]   adr_q, wdata_q;
  logic          we_q;
  logic [31:0]   cyccnt;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [31:0]   t_adr, t_wdata;
  logic          t_we;
  logic          commit;
  logic          misaligned, is_led, is_cnt, in_ram, ram_we;
  logic [AW-1:0] ram_idx;

  // With zero wait states the commit happens on the same edge that samples req.
  // Because of that, the live bus inputs are used while idle. In every other
  // state the latched copy is used.
  assign t_adr   = (state == S_IDLE) ? adr       : adr_q;
  assign t_wdata = (state == S_IDLE) ? writedata : wdata_q;
  assign t_we    = (state == S_IDLE) ? memwrite  : we_q;

  assign misaligned = (t_adr[1:0] != 2'b00);
  assign is_led     = (t_adr == MMIO_BASE);
  assign is_cnt     = (t_adr == MMIO_BASE + 32'd4);
  assign in_ram     = (t_adr[31:2] < 30'(DEPTH_WORDS));
  assign ram_idx    = t_adr[AW+1:2];
  assign ram_we     = t_we && !misaligned && !is_led && !is_cnt && in_ram;

  // DONE is always followed by IDLE, so "next state is DONE" is exactly the
  // edge that enters DONE, which is where the decoded action takes effect.
  assign commit = (state_next == S_DONE);
  assign ready  = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req) state_next = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
      S_WAIT:  if (wcnt == 8'd1) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt     <= 8'd0;
      adr_q    <= 32'd0;
      wdata_q  <= 32'd0;
      we_q     <= 1'b0;
      cyccnt   <= 32'd0;
      readdata <= 32'd0;
      err      <= 1'b0;
      leds     <= 8'd0;
    end else begin
      cyccnt <= cyccnt + 32'd1;
      if (state == S_IDLE && req) begin
        adr_q   <= adr;
        wdata_q <= writedata;
        we_q    <= memwrite;
        wcnt    <= 8'(WAIT_CYCLES);
      end else if (state == S_WAIT) begin
        wcnt <= wcnt - 8'd1;
      end
      if (commit) begin
        err <= 1'b0;
        if (misaligned) begin
          err      <= 1'b1;
          readdata <= 32'd0;
        end else if (is_led) begin
          if (t_we) leds     <= t_wdata[7:0];
          else      readdata <= {24'd0, leds};
        end else if (is_cnt) begin
          // Counter reads return the value held at the commit edge; writes are ignored.
          if (!t_we) readdata <= cyccnt;
        end else if (in_ram) begin
          if (!t_we) readdata <= mem[ram_idx];
        end else begin
          err      <= 1'b1;
          readdata <= 32'd0;
        end
      end
    end
  end

  // RAM contents survive reset, but a reset on the commit edge still cancels the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && ram_we) mem[ram_idx] <= t_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Scoreboard bench for mem_responder. A transaction-level model predicts every
//   response when the request is issued. The prediction is queued and compared by
//   an independent monitor whenever ready is seen. A second instance with zero
//   wait states covers the back-to-back single-cycle case.
module tb_mem_responder;

  localparam int          W    = 2;
  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset, req, memwrite;
  logic [31:0] adr, writedata, readdata;
  logic        ready, err;
  logic [7:0]  leds;

  logic        req0, memwrite0;
  logic [31:0] adr0, writedata0, readdata0;
  logic        ready0, err0;
  logic [7:0]  leds0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic [7:0]  leds;
    int          commitEdge;
  } exp_t;

  exp_t        expQ[$];
  int          testsRun = 0, testsFailed = 0;
  int          edgeCount = 0, lastRst = 0;
  logic [31:0] ramModel [64];
  logic [7:0]  ledModel;
  logic [31:0] rdModel;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(W), .MMIO_BASE(BASE)) u_dut (
    .clk(clk), .reset(reset), .req(req), .adr(adr), .writedata(writedata),
    .memwrite(memwrite), .readdata(readdata), .ready(ready), .err(err), .leds(leds)
  );

  mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0), .MMIO_BASE(BASE)) u_dut0 (
    .clk(clk), .reset(reset), .req(req0), .adr(adr0), .writedata(writedata0),
    .memwrite(memwrite0), .readdata(readdata0), .ready(ready0), .err(err0), .leds(leds0)
  );

  // Edge numbering shared by stimulus and monitor; the counter register equals
  // the number of non-reset edges since the last edge that sampled reset.
  always @(posedge clk) begin
    edgeCount++;
    if (reset) lastRst = edgeCount;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    testsRun++;
    if (act !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic finishRun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  endtask

  // Monitor: every ready pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    exp_t e;
    if (ready === 1'b1) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_ready: got ready=1 at edge %0d, expected no pulse", edgeCount);
      end else begin
        e = expQ.pop_front();
        checkOutput("ready_edge", 32'(edgeCount), 32'(e.commitEdge));
        checkOutput("readdata", readdata, e.rd);
        checkOutput("err", {31'd0, err}, {31'd0, e.err});
        checkOutput("leds", {24'd0, leds}, {24'd0, e.leds});
      end
    end
  end

  // Issue one transaction. In back-to-back mode the call starts in the DONE
  // cycle of the previous transaction, so req is first sampled two edges later.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                               input logic w, input bit b2b);
    exp_t e;
    int   s, n;
    logic [31:0] idx;
    if (!b2b) begin
      req = 1'b0;
      @(negedge clk);
      s = edgeCount + 1;
    end else begin
      s = edgeCount + 2;
    end
    adr = a; writedata = d; memwrite = w; req = 1'b1;
    e.commitEdge = s + W;
    e.err = 1'b0;
    idx = a >> 2;
    if (a[1:0] != 2'b00) begin
      e.err = 1'b1; rdModel = 32'd0;
    end else if (a == BASE) begin
      if (w) ledModel = d[7:0];
      else   rdModel = {24'd0, ledModel};
    end else if (a == BASE + 32'd4) begin
      if (!w) rdModel = 32'(e.commitEdge - lastRst - 1);
    end else if (idx < 32'd64) begin
      if (w) ramModel[idx[5:0]] = d;
      else   rdModel = ramModel[idx[5:0]];
    end else begin
      e.err = 1'b1; rdModel = 32'd0;
    end
    e.rd = rdModel;
    e.leds = ledModel;
    expQ.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready !== 1'b1 && n < 50);
    if (ready !== 1'b1) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL ready_timeout: got no ready within %0d cycles, expected one", n);
      finishRun();
    end
  endtask

  // Start a transaction and reset k edges after req is sampled (k=W hits the commit edge).
  task automatic abortTxn(input logic [31:0] a, input logic [31:0] d, input logic w, input int k);
    req = 1'b0;
    @(negedge clk);
    adr = a; writedata = d; memwrite = w; req = 1'b1;
    repeat (k) @(negedge clk);
    reset = 1'b1; req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    ledModel = 8'd0;
    rdModel  = 32'd0;
    repeat (W + 2) @(negedge clk);
    checkOutput("abort_ready", {31'd0, ready}, 32'd0);
    checkOutput("abort_leds", {24'd0, leds}, 32'd0);
    checkOutput("abort_readdata", readdata, 32'd0);
    checkOutput("abort_err", {31'd0, err}, 32'd0);
  endtask

  function automatic logic [31:0] randomAdr(output logic w);
    logic [31:0] a;
    int kind;
    kind = int'($urandom_range(0, 9));
    w = 1'($urandom_range(0, 1));
    case (kind)
      0, 1, 2, 3, 4: a = 32'($urandom_range(0, 63)) << 2;
      5:             a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      6: begin
        case ($urandom_range(0, 4))
          0:       a = 32'h0000_0100;
          1:       a = 32'h0000_1000;
          2:       a = BASE + 32'd8;
          3:       a = BASE - 32'd4;
          default: a = 32'h8000_0000;
        endcase
      end
      7:       a = BASE;
      default: a = BASE + 32'd4;
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] a, d, prev, expVal;
    logic        w;
    reset = 1'b1; req = 1'b0; adr = 32'd0; writedata = 32'd0; memwrite = 1'b0;
    req0 = 1'b0; adr0 = 32'd0; writedata0 = 32'd0; memwrite0 = 1'b0;
    ledModel = 8'd0; rdModel = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_err", {31'd0, err}, 32'd0);
    checkOutput("reset_readdata", readdata, 32'd0);
    checkOutput("reset_leds", {24'd0, leds}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 64; i++) applyStimulus(32'(i) << 2, $urandom, 1'b1, 1'b0);

    applyStimulus(32'h10, 32'h12345678, 1'b1, 1'b0);
    applyStimulus(32'h10, 32'h0, 1'b0, 1'b0);

    applyStimulus(32'h6, 32'h0, 1'b0, 1'b0);
    applyStimulus(32'h100, 32'hCAFEF00D, 1'b1, 1'b0);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

    applyStimulus(BASE, 32'h000000A5, 1'b1, 1'b0);
    applyStimulus(BASE, 32'h0, 1'b0, 1'b0);
    applyStimulus(BASE + 32'd4, 32'hFFFFFFFF, 1'b1, 1'b0);

    applyStimulus(BASE + 32'd4, 32'h0, 1'b0, 1'b0);
    applyStimulus(BASE + 32'd4, 32'h0, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      a = randomAdr(w);
      d = $urandom;
      applyStimulus(a, d, w, ($urandom_range(0, 3) == 0));
    end

    applyStimulus(32'h20, 32'h1, 1'b1, 1'b0);
    applyStimulus(BASE, 32'h5A, 1'b1, 1'b0);
    abortTxn(32'h20, 32'hDEAD, 1'b1, 1);
    applyStimulus(32'h20, 32'h0, 1'b0, 1'b0);
    applyStimulus(BASE, 32'h3C, 1'b1, 1'b0);
    abortTxn(32'h24, 32'hBEEF, 1'b1, W);
    applyStimulus(32'h24, 32'h0, 1'b0, 1'b0);
    abortTxn(32'h28, 32'hF00D, 1'b1, 0);
    applyStimulus(32'h28, 32'h0, 1'b0, 1'b0);
    req = 1'b0;

    // Zero-wait instance: req held for six cycles gives ready 0,1,0,1,0,1.
    @(negedge clk);
    prev = 32'd0;
    adr0 = BASE + 32'd4; memwrite0 = 1'b0; req0 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("w0_ready", {31'd0, ready0}, 32'(i % 2));
      if (i % 2 == 1) begin
        expVal = 32'(edgeCount - lastRst - 1);
        checkOutput("w0_readdata", readdata0, expVal);
        prev = expVal;
      end else begin
        checkOutput("w0_readdata_hold", readdata0, prev);
      end
    end
    req0 = 1'b0;

    repeat (4) @(negedge clk);
    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL pending_responses: got %0d outstanding, expected 0", expQ.size());
    end
    finishRun();
  end

  initial begin
    #1000000;
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL watchdog: got no completion by time limit, expected finish");
    finishRun();
  end

endmodule
